onehot_sequencer: RTL

//  Parametrised, registered one-hot decoder with a command interface. An SEL_W-bit index is

---
 rtl/onehot_seq_pkg.sv | 20 ++
 rtl/onehot_decode.sv | 15 +
 rtl/onehot_sequencer.sv | 149 ++++++++++++++
 3 files changed

// File: rtl/onehot_seq_pkg.sv
// Shared encodings for the one-hot sequencer: command opcodes, FSM states and
// rotation directions.
package onehot_seq_pkg;

  typedef enum logic [1:0] {
    OP_LOAD  = 2'b00,
    OP_STEP  = 2'b01,
    OP_RUN   = 2'b10,
    OP_CLEAR = 2'b11
  } op_e;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_e;

  localparam logic DIR_LEFT  = 1'b0;
  localparam logic DIR_RIGHT = 1'b1;

endpackage

// File: rtl/onehot_decode.sv
// Combinational binary-index to one-hot decoder; 2**SEL_W outputs.
module onehot_decode #(
  parameter int SEL_W = 3
) (
  input  logic [SEL_W-1:0]      idx,
  output logic [(1<<SEL_W)-1:0] onehot
);

  // Set exactly the bit selected by idx.
  always_comb begin
    onehot      = '0;
    onehot[idx] = 1'b1;
  end

endmodule

// File: rtl/onehot_sequencer.sv
// Registered one-hot select with LOAD / STEP / RUN / CLEAR commands and a
// two-state RUN FSM that auto-rotates for a programmed number of edges.
module onehot_sequencer
  import onehot_seq_pkg::*;
#(
  parameter  int SEL_W     = 3,
  parameter  int CNT_W     = 8,
  parameter  int RESET_IDX = 0,
  localparam int OUT_W     = 1 << SEL_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [1:0]       cmd_op,
  input  logic             cmd_dir,
  input  logic [SEL_W-1:0] cmd_idx,
  input  logic [CNT_W-1:0] cmd_cnt,
  input  logic             abort,
  output logic [OUT_W-1:0] out_onehot,
  output logic [SEL_W-1:0] out_idx,
  output logic             out_valid,
  output logic             done
);

  localparam logic [SEL_W-1:0] RESET_SEL = SEL_W'(RESET_IDX);
  localparam logic [OUT_W-1:0] RESET_OH  = OUT_W'(1) << RESET_IDX;

  state_e             state_r, state_s;
  logic [CNT_W-1:0]   cnt_r, cnt_s;
  logic               dir_r, dir_s;
  logic [OUT_W-1:0]   onehot_r, onehot_s;
  logic [SEL_W-1:0]   idx_r, idx_s;
  logic               valid_r, valid_s;
  logic               done_r, done_s;

  logic               step_dir_s;
  logic [OUT_W-1:0]   step_oh_s;
  logic [SEL_W-1:0]   step_idx_s;
  logic [OUT_W-1:0]   load_oh_s;

  onehot_decode #(.SEL_W(SEL_W)) u_decode (
    .idx    (cmd_idx),
    .onehot (load_oh_s)
  );

  // A RUN rotates in its latched direction; a STEP uses the live command bit.
  assign step_dir_s = (state_r == ST_RUN) ? dir_r : cmd_dir;

  // One-position rotation of both the vector and its index; a cleared vector stays zero.
  always_comb begin
    step_oh_s  = onehot_r;
    step_idx_s = idx_r;
    if (step_dir_s == DIR_RIGHT) begin
      step_oh_s  = {onehot_r[0], onehot_r[OUT_W-1:1]};
      step_idx_s = idx_r - SEL_W'(1);
    end else begin
      step_oh_s  = {onehot_r[OUT_W-2:0], onehot_r[OUT_W-1]};
      step_idx_s = idx_r + SEL_W'(1);
    end
  end

  // Next-state and next-output logic for command accept and the RUN sequence.
  always_comb begin
    state_s  = state_r;
    cnt_s    = cnt_r;
    dir_s    = dir_r;
    onehot_s = onehot_r;
    idx_s    = idx_r;
    valid_s  = valid_r;
    done_s   = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (cmd_valid) begin
          case (cmd_op)
            OP_LOAD: begin
              onehot_s = load_oh_s;
              idx_s    = cmd_idx;
              valid_s  = 1'b1;
            end
            OP_STEP: begin
              onehot_s = step_oh_s;
              idx_s    = step_idx_s;
            end
            OP_RUN: begin
              state_s = ST_RUN;
              cnt_s   = cmd_cnt;
              dir_s   = cmd_dir;
            end
            OP_CLEAR: begin
              onehot_s = '0;
              idx_s    = '0;
              valid_s  = 1'b0;
            end
            default: begin
              state_s = ST_IDLE;
            end
          endcase
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_RUN: begin
        // abort outranks the final count so a cut-short run never reports done
        if (abort) begin
          state_s = ST_IDLE;
        end else if (cnt_r == '0) begin
          state_s = ST_IDLE;
          done_s  = 1'b1;
        end else begin
          onehot_s = step_oh_s;
          idx_s    = step_idx_s;
          cnt_s    = cnt_r - CNT_W'(1);
        end
      end
      default: begin
        state_s = ST_IDLE;
      end
    endcase
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r  <= ST_IDLE;
      cnt_r    <= '0;
      dir_r    <= DIR_LEFT;
      onehot_r <= RESET_OH;
      idx_r    <= RESET_SEL;
      valid_r  <= 1'b1;
      done_r   <= 1'b0;
    end else begin
      state_r  <= state_s;
      cnt_r    <= cnt_s;
      dir_r    <= dir_s;
      onehot_r <= onehot_s;
      idx_r    <= idx_s;
      valid_r  <= valid_s;
      done_r   <= done_s;
    end
  end

  assign cmd_ready  = (state_r == ST_IDLE);
  assign out_onehot = onehot_r;
  assign out_idx    = idx_r;
  assign out_valid  = valid_r;
  assign done       = done_r;

endmodule
